// File: rtl/rob_pkg.sv
// Shared types and defaults for the reorder buffer slice.
// Latency: n/a (types only).
// Backpressure: n/a.
package rob_pkg;

  localparam int ROB_DEPTH_DFLT = 16;
  localparam int PREG_BITS      = 6;

  // One reorder-buffer slot.
  typedef struct packed {
    logic                 valid;
    logic                 done;
    logic [4:0]           rd_s;
    logic [PREG_BITS-1:0] paddr;
    logic [31:0]          data;
  } rob_entry_t;

  // Signals presented on the RAT/ARF commit port.
  typedef struct packed {
    logic                 we_rd_rename;
    logic                 we_rd_data;
    logic [4:0]           rd_s;
    logic                 rd_rename_v;
    logic [31:0]          rd_v;
    logic [PREG_BITS-1:0] rd_old_paddr;
  } commit_bus_t;

endpackage

// File: rtl/rob_ptr_ctrl.sv
// Head/tail/occupancy bookkeeping for the reorder buffer, wrapping modulo DEPTH.
// Latency: pointers and count update on the clock edge after push/pop/flush.
// Backpressure: exposes full; the caller must not push while full.
module rob_ptr_ctrl #(
  parameter int DEPTH    = 16,
  parameter int IDX_BITS = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                flush,
  input  logic                push,
  input  logic                pop,
  output logic [IDX_BITS-1:0] head,
  output logic [IDX_BITS-1:0] tail,
  output logic [IDX_BITS:0]   count,
  output logic                full,
  output logic                empty
);

  localparam logic [IDX_BITS:0] FULL_CNT = (IDX_BITS+1)'(DEPTH);

  // Pointer and count registers; flush returns everything to slot 0.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else if (flush) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      if (push) tail <= tail + 1'b1;
      if (pop)  head <= head + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  assign full  = (count == FULL_CNT);
  assign empty = (count == '0);

endmodule

// File: rtl/rob_commit.sv
// In-order reorder buffer: allocate at dispatch, mark done on CDB, retire one per cycle.
// Latency: commit outputs are registered one cycle after the head is seen done.
// Backpressure: disp_ready drops when full or during flush; no same-cycle bypass from commit.
module rob_commit
  import rob_pkg::*;
#(
  parameter int ROB_DEPTH     = ROB_DEPTH_DFLT,
  parameter int PHYS_REG_BITS = PREG_BITS,
  localparam int ROB_IDX_BITS = $clog2(ROB_DEPTH)
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     br_rst,
  input  logic                     disp_valid,
  output logic                     disp_ready,
  input  logic [4:0]               disp_rd_s,
  input  logic [PHYS_REG_BITS-1:0] disp_paddr,
  output logic [ROB_IDX_BITS-1:0]  disp_rob_idx,
  input  logic                     cdb_valid,
  input  logic [ROB_IDX_BITS-1:0]  cdb_rob_idx,
  input  logic [31:0]              cdb_data,
  output logic                     we_rd_rename,
  output logic                     we_rd_data,
  output logic [4:0]               rd_s,
  output logic                     rd_rename_v,
  output logic [31:0]              rd_v,
  output logic [PHYS_REG_BITS-1:0] rd_old_paddr,
  output logic                     free_valid,
  output logic [PHYS_REG_BITS-1:0] free_paddr,
  output logic                     rob_empty,
  output logic [ROB_IDX_BITS:0]    rob_count
);

  rob_entry_t                  entries [ROB_DEPTH];
  rob_entry_t                  head_e;
  logic [ROB_IDX_BITS-1:0]     head;
  logic [ROB_IDX_BITS-1:0]     tail;
  logic [ROB_IDX_BITS:0]       count;
  logic                        full;
  logic                        empty;
  logic                        commit;
  logic                        disp_fire;
  commit_bus_t                 cbus_q;
  logic                        free_valid_q;
  logic [PHYS_REG_BITS-1:0]    free_paddr_q;

  assign head_e    = entries[head];
  // A done head retires even during a flush: it is older than the branch.
  assign commit    = head_e.valid & head_e.done;
  assign disp_ready = ~full & ~br_rst;
  assign disp_fire = disp_valid & disp_ready;

  rob_ptr_ctrl #(
    .DEPTH    (ROB_DEPTH),
    .IDX_BITS (ROB_IDX_BITS)
  ) u_ptr (
    .clk   (clk),
    .rst_n (rst_n),
    .flush (br_rst),
    .push  (disp_fire),
    .pop   (commit),
    .head  (head),
    .tail  (tail),
    .count (count),
    .full  (full),
    .empty (empty)
  );

  // Entry storage: flush clears all; otherwise CDB completes, commit retires, dispatch allocates.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < ROB_DEPTH; i++) entries[i] <= '0;
    end else if (br_rst) begin
      for (int i = 0; i < ROB_DEPTH; i++) entries[i] <= '0;
    end else begin
      if (cdb_valid && entries[cdb_rob_idx].valid) begin
        entries[cdb_rob_idx].done <= 1'b1;
        entries[cdb_rob_idx].data <= cdb_data;
      end
      if (commit) begin
        entries[head].valid <= 1'b0;
        entries[head].done  <= 1'b0;
      end
      if (disp_fire) begin
        entries[tail] <= '{valid: 1'b1, done: 1'b0, rd_s: disp_rd_s,
                           paddr: disp_paddr, data: 32'd0};
      end
    end
  end

  // Commit port: enables pulse for one cycle, data fields hold between commits.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cbus_q       <= '0;
      free_valid_q <= 1'b0;
      free_paddr_q <= '0;
    end else if (commit) begin
      cbus_q.we_rd_rename <= (head_e.rd_s != 5'd0);
      cbus_q.we_rd_data   <= (head_e.rd_s != 5'd0);
      cbus_q.rd_s         <= head_e.rd_s;
      cbus_q.rd_rename_v  <= 1'b0;
      cbus_q.rd_v         <= head_e.data;
      cbus_q.rd_old_paddr <= head_e.paddr;
      free_valid_q        <= 1'b1;
      free_paddr_q        <= head_e.paddr;
    end else begin
      cbus_q.we_rd_rename <= 1'b0;
      cbus_q.we_rd_data   <= 1'b0;
      free_valid_q        <= 1'b0;
    end
  end

  assign we_rd_rename = cbus_q.we_rd_rename;
  assign we_rd_data   = cbus_q.we_rd_data;
  assign rd_s         = cbus_q.rd_s;
  assign rd_rename_v  = cbus_q.rd_rename_v;
  assign rd_v         = cbus_q.rd_v;
  assign rd_old_paddr = cbus_q.rd_old_paddr;
  assign free_valid   = free_valid_q;
  assign free_paddr   = free_paddr_q;
  assign disp_rob_idx = tail;
  assign rob_empty    = empty;
  assign rob_count    = count;

endmodule

// File: tb/tb_rob_commit.sv
// Directed bench for rob_commit: vector table plus hand-written multi-cycle sequences.
// Latency: inputs driven 1ns after the rising edge, outputs checked 1ns after the next.
// Backpressure: disp_ready checked before each dispatch edge.
module tb_rob_commit;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        br_rst = 1'b0;
  logic        disp_valid = 1'b0;
  logic        disp_ready;
  logic [4:0]  disp_rd_s = '0;
  logic [5:0]  disp_paddr = '0;
  logic [3:0]  disp_rob_idx;
  logic        cdb_valid = 1'b0;
  logic [3:0]  cdb_rob_idx = '0;
  logic [31:0] cdb_data = '0;
  logic        we_rd_rename, we_rd_data, rd_rename_v, free_valid, rob_empty;
  logic [4:0]  rd_s;
  logic [31:0] rd_v;
  logic [5:0]  rd_old_paddr, free_paddr;
  logic [4:0]  rob_count;

  int total = 0;
  int bad   = 0;

  rob_commit dut (
    .clk(clk), .rst_n(rst_n), .br_rst(br_rst),
    .disp_valid(disp_valid), .disp_ready(disp_ready), .disp_rd_s(disp_rd_s),
    .disp_paddr(disp_paddr), .disp_rob_idx(disp_rob_idx),
    .cdb_valid(cdb_valid), .cdb_rob_idx(cdb_rob_idx), .cdb_data(cdb_data),
    .we_rd_rename(we_rd_rename), .we_rd_data(we_rd_data), .rd_s(rd_s),
    .rd_rename_v(rd_rename_v), .rd_v(rd_v), .rd_old_paddr(rd_old_paddr),
    .free_valid(free_valid), .free_paddr(free_paddr),
    .rob_empty(rob_empty), .rob_count(rob_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        dv;
    logic [4:0]  rd;
    logic [5:0]  pa;
    logic        cv;
    logic [3:0]  ci;
    logic [31:0] cd;
    logic        e_rdy;
    logic [3:0]  e_idx;
    logic        e_fv;
    logic        e_we;
    logic [4:0]  e_rd;
    logic [31:0] e_v;
    logic [5:0]  e_pa;
    logic [4:0]  e_cnt;
  } vec_t;

  vec_t tbl [21];

  function automatic vec_t mk(logic dv, logic [4:0] rd, logic [5:0] pa, logic cv,
                              logic [3:0] ci, logic [31:0] cd, logic e_rdy, logic [3:0] e_idx,
                              logic e_fv, logic e_we, logic [4:0] e_rd, logic [31:0] e_v,
                              logic [5:0] e_pa, logic [4:0] e_cnt);
    vec_t v;
    v.dv = dv; v.rd = rd; v.pa = pa; v.cv = cv; v.ci = ci; v.cd = cd;
    v.e_rdy = e_rdy; v.e_idx = e_idx; v.e_fv = e_fv; v.e_we = e_we;
    v.e_rd = e_rd; v.e_v = e_v; v.e_pa = e_pa; v.e_cnt = e_cnt;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clr_in();
    disp_valid = 1'b0; disp_rd_s = '0; disp_paddr = '0;
    cdb_valid = 1'b0; cdb_rob_idx = '0; cdb_data = '0; br_rst = 1'b0;
  endtask

  task automatic do_reset();
    clr_in();
    #2 rst_n = 1'b0;
    #1;
    chk("rst_fv", free_valid, 0);
    chk("rst_cnt", rob_count, 0);
    @(negedge clk) rst_n = 1'b1;
    step();
  endtask

  logic [4:0]  h_rd = '0;
  logic [31:0] h_v  = '0;
  logic [5:0]  h_pa = '0;

  initial begin
    // Commit-port data fields hold between commits; the bench tracks the last commit.
    tbl[0]  = mk(0,  0, 6'h00, 0, 0, 32'h0,        1, 0, 0, 0,  0, 32'h0,        6'h00, 0);
    tbl[1]  = mk(1,  5, 6'h12, 0, 0, 32'h0,        1, 0, 0, 0,  0, 32'h0,        6'h00, 1);
    tbl[2]  = mk(0,  0, 6'h00, 1, 0, 32'hDEADBEEF, 1, 1, 0, 0,  0, 32'h0,        6'h00, 1);
    tbl[3]  = mk(0,  0, 6'h00, 0, 0, 32'h0,        1, 1, 1, 1,  5, 32'hDEADBEEF, 6'h12, 0);
    tbl[4]  = mk(0,  0, 6'h00, 0, 0, 32'h0,        1, 1, 0, 0,  0, 32'h0,        6'h00, 0);
    tbl[5]  = mk(1,  1, 6'h21, 0, 0, 32'h0,        1, 1, 0, 0,  0, 32'h0,        6'h00, 1);
    tbl[6]  = mk(1,  2, 6'h22, 0, 0, 32'h0,        1, 2, 0, 0,  0, 32'h0,        6'h00, 2);
    tbl[7]  = mk(1,  3, 6'h23, 0, 0, 32'h0,        1, 3, 0, 0,  0, 32'h0,        6'h00, 3);
    tbl[8]  = mk(0,  0, 6'h00, 1, 3, 32'h3333,     1, 4, 0, 0,  0, 32'h0,        6'h00, 3);
    tbl[9]  = mk(0,  0, 6'h00, 0, 0, 32'h0,        1, 4, 0, 0,  0, 32'h0,        6'h00, 3);
    tbl[10] = mk(0,  0, 6'h00, 1, 1, 32'h1111,     1, 4, 0, 0,  0, 32'h0,        6'h00, 3);
    tbl[11] = mk(0,  0, 6'h00, 1, 2, 32'h2222,     1, 4, 1, 1,  1, 32'h1111,     6'h21, 2);
    tbl[12] = mk(0,  0, 6'h00, 0, 0, 32'h0,        1, 4, 1, 1,  2, 32'h2222,     6'h22, 1);
    tbl[13] = mk(0,  0, 6'h00, 0, 0, 32'h0,        1, 4, 1, 1,  3, 32'h3333,     6'h23, 0);
    tbl[14] = mk(0,  0, 6'h00, 0, 0, 32'h0,        1, 4, 0, 0,  0, 32'h0,        6'h00, 0);
    tbl[15] = mk(1,  0, 6'h30, 0, 0, 32'h0,        1, 4, 0, 0,  0, 32'h0,        6'h00, 1);
    tbl[16] = mk(0,  0, 6'h00, 1, 4, 32'hCAFE,     1, 5, 0, 0,  0, 32'h0,        6'h00, 1);
    tbl[17] = mk(0,  0, 6'h00, 0, 0, 32'h0,        1, 5, 1, 0,  0, 32'hCAFE,     6'h30, 0);
    tbl[18] = mk(0,  0, 6'h00, 0, 0, 32'h0,        1, 5, 0, 0,  0, 32'h0,        6'h00, 0);
    tbl[19] = mk(0,  0, 6'h00, 1, 9, 32'hBAD0,     1, 5, 0, 0,  0, 32'h0,        6'h00, 0);
    tbl[20] = mk(0,  0, 6'h00, 0, 0, 32'h0,        1, 5, 0, 0,  0, 32'h0,        6'h00, 0);

    // Reset and idle.
    #12;
    chk("rst_empty", rob_empty, 1);
    chk("rst_rdy", disp_ready, 1);
    chk("rst_rename_v", rd_rename_v, 0);
    @(negedge clk) rst_n = 1'b1;
    for (int i = 0; i < 10; i++) begin
      step();
      chk($sformatf("idle%0d_empty", i), rob_empty, 1);
      chk($sformatf("idle%0d_rdy", i), disp_ready, 1);
      chk($sformatf("idle%0d_we", i), {we_rd_data, we_rd_rename, free_valid}, 0);
    end

    // Table: single instruction, out-of-order completion, x0 destination, stray CDB.
    for (int i = 0; i < 21; i++) begin
      disp_valid = tbl[i].dv; disp_rd_s = tbl[i].rd; disp_paddr = tbl[i].pa;
      cdb_valid = tbl[i].cv; cdb_rob_idx = tbl[i].ci; cdb_data = tbl[i].cd;
      #1;
      chk($sformatf("r%0d_rdy", i), disp_ready, tbl[i].e_rdy);
      chk($sformatf("r%0d_idx", i), disp_rob_idx, tbl[i].e_idx);
      step();
      clr_in();
      if (tbl[i].e_fv) begin
        h_rd = tbl[i].e_rd; h_v = tbl[i].e_v; h_pa = tbl[i].e_pa;
      end
      chk($sformatf("r%0d_fv", i), free_valid, tbl[i].e_fv);
      chk($sformatf("r%0d_we_data", i), we_rd_data, tbl[i].e_we);
      chk($sformatf("r%0d_we_ren", i), we_rd_rename, tbl[i].e_we);
      chk($sformatf("r%0d_rd_s", i), rd_s, h_rd);
      chk($sformatf("r%0d_rd_v", i), rd_v, h_v);
      chk($sformatf("r%0d_old_pa", i), rd_old_paddr, h_pa);
      chk($sformatf("r%0d_free_pa", i), free_paddr, h_pa);
      chk($sformatf("r%0d_cnt", i), rob_count, tbl[i].e_cnt);
    end

    // Full and wrap.
    do_reset();
    for (int i = 0; i < 16; i++) begin
      disp_valid = 1'b1; disp_rd_s = 5'(i + 1); disp_paddr = 6'(i);
      #1;
      chk($sformatf("full_idx%0d", i), disp_rob_idx, i);
      chk($sformatf("full_rdy%0d", i), disp_ready, 1);
      step();
    end
    disp_valid = 1'b1; disp_rd_s = 5'd31; disp_paddr = 6'h3E;
    #1;
    chk("full_rdy_low", disp_ready, 0);
    chk("full_cnt16", rob_count, 16);
    step();
    chk("full_held_ignored", rob_count, 16);
    clr_in();
    cdb_valid = 1'b1; cdb_rob_idx = 4'd0; cdb_data = 32'hA0;
    step();
    cdb_rob_idx = 4'd1; cdb_data = 32'hA1;
    #1;
    chk("full_no_bypass", disp_ready, 0);
    step();
    clr_in();
    chk("wrap_c0_fv", free_valid, 1);
    chk("wrap_c0_rd", rd_s, 1);
    chk("wrap_c0_v", rd_v, 32'hA0);
    chk("wrap_c0_pa", free_paddr, 0);
    chk("wrap_c0_cnt", rob_count, 15);
    disp_valid = 1'b1; disp_rd_s = 5'd7; disp_paddr = 6'h3F;
    #1;
    chk("wrap_rdy", disp_ready, 1);
    chk("wrap_idx0", disp_rob_idx, 0);
    step();
    clr_in();
    chk("wrap_c1_fv", free_valid, 1);
    chk("wrap_c1_rd", rd_s, 2);
    chk("wrap_c1_v", rd_v, 32'hA1);
    chk("wrap_c1_pa", free_paddr, 1);
    chk("wrap_cnt_same", rob_count, 15);
    chk("wrap_next_idx", disp_rob_idx, 1);

    // Flush with a done head and a concurrent CDB to idx 2.
    do_reset();
    for (int i = 0; i < 4; i++) begin
      disp_valid = 1'b1; disp_rd_s = 5'(10 + i); disp_paddr = 6'(8'h28 + i);
      step();
    end
    clr_in();
    cdb_valid = 1'b1; cdb_rob_idx = 4'd0; cdb_data = 32'h55;
    step();
    cdb_rob_idx = 4'd2; cdb_data = 32'h77; br_rst = 1'b1;
    disp_valid = 1'b1; disp_rd_s = 5'd9; disp_paddr = 6'd9;
    #1;
    chk("flush_rdy", disp_ready, 0);
    step();
    clr_in();
    chk("flush_fv", free_valid, 1);
    chk("flush_rd", rd_s, 10);
    chk("flush_v", rd_v, 32'h55);
    chk("flush_pa", free_paddr, 6'h28);
    chk("flush_cnt", rob_count, 0);
    chk("flush_empty", rob_empty, 1);
    chk("flush_idx", disp_rob_idx, 0);
    for (int i = 0; i < 3; i++) begin
      step();
      chk($sformatf("flush_after%0d_fv", i), free_valid, 0);
    end
    disp_valid = 1'b1; disp_rd_s = 5'd4; disp_paddr = 6'd4;
    #1;
    chk("flush_next_idx", disp_rob_idx, 0);
    step();
    clr_in();
    chk("flush_next_cnt", rob_count, 1);

    // Async reset while a commit pulse is showing and more entries are pending.
    for (int i = 0; i < 2; i++) begin
      disp_valid = 1'b1; disp_rd_s = 5'(20 + i); disp_paddr = 6'(20 + i);
      step();
    end
    clr_in();
    cdb_valid = 1'b1; cdb_rob_idx = 4'd0; cdb_data = 32'h11;
    step();
    cdb_rob_idx = 4'd1; cdb_data = 32'h22;
    step();
    clr_in();
    chk("ar_pre_fv", free_valid, 1);
    chk("ar_pre_cnt", rob_count, 2);
    #2 rst_n = 1'b0;
    #1;
    chk("ar_fv", free_valid, 0);
    chk("ar_we", {we_rd_data, we_rd_rename}, 0);
    chk("ar_rd_v", rd_v, 0);
    chk("ar_rd_s", rd_s, 0);
    chk("ar_cnt", rob_count, 0);
    chk("ar_empty", rob_empty, 1);
    chk("ar_rdy", disp_ready, 1);
    @(negedge clk) rst_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step();
      chk($sformatf("ar_after%0d_fv", i), free_valid, 0);
      chk($sformatf("ar_after%0d_cnt", i), rob_count, 0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
